// File: rtl/mul_datapath_pkg.sv
// Default operand/product widths for the repeated-addition multiplier datapath.
// The macros are guarded so the defaults can be overridden before this file is read.
`ifndef MUL_DATAPATH_DEFS
`define MUL_DATAPATH_DEFS
`define MUL_DP_WIDTH 16
`define MUL_DP_PWIDTH 16
`endif

package mul_datapath_pkg;
    localparam int DEF_WIDTH  = `MUL_DP_WIDTH;
    localparam int DEF_PWIDTH = `MUL_DP_PWIDTH;
endpackage

// File: rtl/mul_dp_reg.sv
// Parameterized register with synchronous clear and load; clear wins over load.
module mul_dp_reg #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // if/else decode so an X on clr with ld=0 leaves q holding in simulation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: operand A, saturating down-counter B,
// accumulator P with sticky carry-out flag. Sequencing belongs to the controller.
module mul_datapath
    import mul_datapath_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PWIDTH = DEF_PWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ldA,
    input  logic              ldB,
    input  logic              ldP,
    input  logic              clrP,
    input  logic              decB,
    output logic              eqz,
    output logic [PWIDTH-1:0] product,
    output logic              ovf
);

    localparam int SW = PWIDTH + 1;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [PWIDTH-1:0] p_q;
    logic [SW-1:0]     sum;
    logic              carry;

    mul_dp_reg #(.W(WIDTH)) u_a (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .ld    (ldA),
        .d     (data_in),
        .q     (a_q)
    );

    // One extra bit on the adder captures the carry-out for the sticky flag
    assign sum   = SW'(p_q) + SW'(a_q);
    assign carry = sum[PWIDTH];

    mul_dp_reg #(.W(PWIDTH)) u_p (
        .clock (clock),
        .reset (reset),
        .clr   (clrP),
        .ld    (ldP),
        .d     (sum[PWIDTH-1:0]),
        .q     (p_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (clrP) begin
            ovf <= 1'b0;
        end else if (ldP) begin
            ovf <= ovf | carry;
        end
    end

    // Down-counter saturates at zero so a stray decrement never wraps to all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            b_q <= '0;
        end else if (ldB) begin
            b_q <= data_in;
        end else if (decB && (b_q != '0)) begin
            b_q <= b_q - WIDTH'(1);
        end
    end

    assign eqz     = (b_q == '0);
    assign product = p_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Directed bench for mul_datapath: stimulus pushes expected {product, ovf, eqz}
// into a queue and a monitor process pops and compares each entry.
module tb_mul_datapath;
    localparam int WIDTH  = 16;
    localparam int PWIDTH = 16;
    localparam int EW     = PWIDTH + 2;

    logic              clock;
    logic              reset;
    logic [WIDTH-1:0]  data_in;
    logic              ldA, ldB, ldP, clrP, decB;
    logic              eqz;
    logic [PWIDTH-1:0] product;
    logic              ovf;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    event          chk_ev;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cnt;

    mul_datapath #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .ldA     (ldA),
        .ldB     (ldB),
        .ldP     (ldP),
        .clrP    (clrP),
        .decB    (decB),
        .eqz     (eqz),
        .product (product),
        .ovf     (ovf)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // monitor: drains the expected queue whenever a check is posted
    always begin
        @(chk_ev);
        while (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            string         n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_cmp++;
            if ({product, ovf, eqz} !== e) begin
                n_err++;
                $display("FAIL %s: got product=%0d ovf=%b eqz=%b, want product=%0d ovf=%b eqz=%b",
                         n, product, ovf, eqz, e[EW-1:2], e[1], e[0]);
            end
        end
    end

    task automatic check(input string n, input logic [PWIDTH-1:0] p, input logic o, input logic z);
        exp_q.push_back({p, o, z});
        name_q.push_back(n);
        -> chk_ev;
        #0;
    endtask

    task automatic check_int(input string n, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", n, got, want);
        end
    endtask

    // driver: strobes applied at the falling edge, released 1 time unit after the rising edge
    task automatic cycle(input logic a, input logic b, input logic p, input logic c,
                         input logic d, input logic [WIDTH-1:0] din);
        @(negedge clock);
        ldA = a; ldB = b; ldP = p; clrP = c; decB = d; data_in = din;
        @(posedge clock);
        #1;
        ldA = 0; ldB = 0; ldP = 0; clrP = 0; decB = 0;
    endtask

    // accumulate until eqz with a cycle budget; an expired budget counts as a failure
    task automatic run_acc(input string n, input int max_cycles, output int steps);
        steps = 0;
        while (!eqz && steps < max_cycles) begin
            cycle(0, 0, 1, 0, 1, '0);
            steps++;
        end
        if (!eqz) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: eqz not seen within %0d cycles", n, max_cycles);
        end
    endtask

    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        cycle(1, 0, 0, 1, 0, a);
        cycle(0, 1, 0, 0, 0, b);
    endtask

    initial begin
        reset = 1'b1;
        data_in = '0; ldA = 0; ldB = 0; ldP = 0; clrP = 0; decB = 0;
        #12;
        check("reset_held", 0, 0, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_released", 0, 0, 1);

        // 5 x 3
        cycle(1, 0, 0, 1, 0, 5);
        check("m53_loadA", 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 3);
        check("m53_loadB", 0, 0, 0);
        cycle(0, 0, 1, 0, 1, '0);
        check("m53_step1", 5, 0, 0);
        cycle(0, 0, 1, 0, 1, '0);
        check("m53_step2", 10, 0, 0);
        cycle(0, 0, 1, 0, 1, '0);
        check("m53_step3", 15, 0, 1);
        cycle(0, 0, 0, 0, 0, '0);
        check("m53_hold", 15, 0, 1);

        // B = 0: eqz immediate, decrement saturates
        start(7, 0);
        check("b0_load", 0, 0, 1);
        cycle(0, 0, 0, 0, 1, '0);
        check("b0_dec1", 0, 0, 1);
        cycle(0, 0, 0, 0, 1, '0);
        check("b0_dec2", 0, 0, 1);

        // overflow: 300 x 300 = 90000 -> 24464
        start(300, 300);
        run_acc("ovf_run", 400, cnt);
        check_int("ovf_steps", cnt, 300);
        check("ovf_result", 16'd24464, 1, 1);
        cycle(0, 0, 0, 1, 0, '0);
        check("ovf_clear", 0, 0, 1);

        // ldB beats decB: B=4 then ldB=9 with decB -> 9 steps of A=2
        start(2, 4);
        cycle(0, 1, 0, 0, 1, 9);
        run_acc("prio_ldb_run", 20, cnt);
        check_int("prio_ldb_steps", cnt, 9);
        check("prio_ldb_prod", 18, 0, 1);

        // clrP beats ldP with P=20
        start(10, 2);
        run_acc("prio_clr_run", 10, cnt);
        check("prio_clr_p20", 20, 0, 1);
        cycle(0, 0, 1, 1, 0, '0);
        check("prio_clr_ldp", 0, 0, 1);

        // clrP = X with ldP = 0 holds P
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1, '0);
        check("clrx_setup", 10, 0, 1);
        cycle(0, 0, 0, 1'bx, 0, '0);
        check("clrx_hold", 10, 0, 1);

        // ldA with ldP: add uses old A (3), then new A (100)
        start(3, 2);
        cycle(1, 0, 1, 0, 1, 100);
        check("lda_ldp_old", 3, 0, 0);
        cycle(0, 0, 1, 0, 1, '0);
        check("lda_ldp_new", 103, 0, 1);

        // reset mid-accumulate of 6 x 4 after two steps
        start(6, 4);
        cycle(0, 0, 1, 0, 1, '0);
        cycle(0, 0, 1, 0, 1, '0);
        check("rst_mid_p12", 12, 0, 0);
        #2;
        ldP = 1; decB = 1;
        reset = 1'b1;
        #1;
        check("rst_mid_async", 0, 0, 1);
        ldP = 0; decB = 0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        // A was cleared: accumulating once adds nothing
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1, '0);
        check("rst_a_zero", 0, 0, 1);
        start(6, 4);
        run_acc("rst_rerun", 10, cnt);
        check_int("rst_rerun_steps", cnt, 4);
        check("rst_rerun_prod", 24, 0, 1);

        // back-to-back without reset
        cycle(1, 0, 0, 1, 0, 2);
        check("b2b_clear", 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 8);
        run_acc("b2b_run", 20, cnt);
        check("b2b_prod", 16, 0, 1);

        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_datapath.md
Name: mul_datapath

Overview:
- Datapath for the repeated-addition multiplier. Holds operand A, down-counting operand B and accumulator P.
- Executes the load, clear, accumulate and decrement strobes issued by the multiplier controller, and returns the zero-detect flag eqz to it.
- Loads both operands from one shared input bus in different cycles. Presents the registered product and a sticky overflow flag to the consumer.

Parameters:
- WIDTH, 16, operand width for A, B and data_in
- PWIDTH, 16, accumulator/product width (PWIDTH >= WIDTH)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  WIDTH  shared operand bus
- ldA  in  1  load A from data_in
- ldB  in  1  load B from data_in
- ldP  in  1  accumulate: P <= P + zero-extended A
- clrP  in  1  clear P and ovf
- decB  in  1  decrement B
- eqz  out  1  combinational: 1 when B == 0
- product  out  PWIDTH  registered P
- ovf  out  1  sticky accumulate carry-out

Behaviour:
- Reset, asynchronous and active-high:
  - A=0, B=0, P=0, ovf=0.
  - eqz=1 while reset is asserted and after it is released.
- All register updates happen on the rising edge of clock. eqz is a pure decode of the B register: no added latency, and it is valid in the same cycle B changes.
- A register:
  - ldA=1 → A <= data_in.
  - Otherwise A holds.
- B register, priority ldB > decB:
  - ldB=1 → B <= data_in, even if decB=1.
  - decB=1 and B != 0 → B <= B-1.
  - decB=1 and B == 0 → B holds at 0. It saturates and never wraps to all-ones.
- P register, priority clrP > ldP:
  - clrP=1 → P <= 0 and ovf <= 0.
  - ldP=1 → P <= (P + {0,A}) mod 2^PWIDTH, and ovf <= ovf | carry-out of that add.
  - Otherwise P and ovf hold.
- clrP may be driven X by the controller in cycles where ldP=0. P and ovf must hold in simulation in that case, so use an if/else priority decode, not arithmetic masking.
- Simultaneous strobes:
  - ldA and ldB together: both load the same data_in.
  - ldA and ldP together: the add uses the old A.
  - ldP and decB together: the normal accumulate step; both operate on pre-edge values.
- Reset mid-operation clears all state immediately, regardless of strobes. The first edge after reset deassertion obeys the strobes present at that edge.
- Operation per controller sequence:
  1. Load A and clear P.
  2. Load B.
  3. For B cycles: P += A, B -= 1.
  4. eqz=1 and product = A*B mod 2^PWIDTH. product stays stable until the next clrP or ldP.
- No internal FSM. This block is pure registered datapath. Sequencing is owned by the controller.

Decomposition:
- Shared include header (guarded with `ifndef): default WIDTH/PWIDTH macros only. No typedefs are needed.
- One natural sub-module: mul_dp_reg, a parameterized load/clear register with clear priority over load. Instantiate it for A (clear tied 0) and for P.
- B's down-counter and the adder/carry logic stay inline in mul_datapath.

Test Plan:
- 5 × 3, WIDTH=PWIDTH=16:
  - Stimulus: ldA+clrP with data_in=5; ldB with data_in=3; three cycles of ldP+decB.
  - Response: P steps 5, 10, 15. B steps 2, 1, 0. eqz rises after the third edge. product=15, ovf=0.
- B=0 edge cases:
  - Stimulus: load A=7 and B=0.
  - Response: eqz=1 immediately after the ldB edge. Two further decB edges leave B=0 (no wrap). product remains 0.
- Overflow, PWIDTH=16:
  - Stimulus: A=300, B=300, run 300 accumulate cycles.
  - Response: product=24464 (90000-65536), ovf=1. Then clrP → product=0, ovf=0.
- Priority:
  - Stimulus: ldB with data_in=9 together with decB while B=4.
  - Response: B=9.
  - Stimulus: clrP together with ldP while P=20.
  - Response: P=0.
  - Stimulus: clrP=X with ldP=0.
  - Response: P unchanged.
- Reset mid-accumulate:
  - Stimulus: assert reset asynchronously between edges during a 6 × 4 run after two steps (P=12).
  - Response: A=B=P=0, eqz=1, ovf=0 with no clock edge. A subsequent full 6 × 4 run gives 24.
- Back-to-back:
  - Stimulus: after done, reload A=2, B=8 without reset.
  - Response: product=16. The previous result is cleared by the load-A/clear-P cycle.
